// File: rtl/bist_pkg.sv
// Shared types and default constants for the BIST response analyzer.
package bist_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    COMPARE = 2'd2,
    DONE    = 2'd3
  } bist_state_t;

  // CRC-16-CCITT style feedback taps
  localparam logic [15:0] DEFAULT_POLY = 16'h1021;

  // One test-mode phase of the comparator pattern source
  localparam int unsigned DEFAULT_PATTERNS = 100;

endpackage

// File: rtl/misr.sv
// Multiple-input signature register.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset, loads SEED
//   load - synchronous reseed to SEED (wins over en)
//   en   - compact din into the signature this edge
//   din  - response vector, zero-extended into the low stages
//   sig  - current signature
module misr #(
  parameter int unsigned             WIDTH = 2,
  parameter int unsigned             SIG_W = 16,
  parameter logic [SIG_W-1:0]        POLY  = SIG_W'(16'h1021),
  parameter logic [SIG_W-1:0]        SEED  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [SIG_W-1:0] sig
);

  logic [SIG_W-1:0] r_sig;
  logic [SIG_W-1:0] w_sig_nxt;
  logic [SIG_W-1:0] w_din_ext;

  // Shift left, fold the outgoing MSB back through the taps, then mix in the response
  always_comb begin
    w_din_ext = {{(SIG_W-WIDTH){1'b0}}, din};
    w_sig_nxt = {r_sig[SIG_W-2:0], 1'b0} ^ (r_sig[SIG_W-1] ? POLY : '0) ^ w_din_ext;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sig <= SEED;
    end else if (load) begin
      r_sig <= SEED;
    end else if (en) begin
      r_sig <= w_sig_nxt;
    end
  end

  assign sig = r_sig;

endmodule

// File: rtl/bist_response_analyzer.sv
// Output-response analyzer: compacts PATTERNS valid response vectors into a
// MISR signature, then compares it against a golden value.
// Ports:
//   clk, rst   - rising-edge clock, asynchronous active-high reset
//   start      - begin a run (honoured in IDLE and DONE only)
//   resp_valid - resp is to be compacted this cycle (CAPTURE only)
//   resp       - DUT response vector {obs, Y}
//   golden     - expected signature, sampled in COMPARE
//   busy       - high in CAPTURE and COMPARE
//   done       - high in DONE
//   pass       - signature matched golden (valid while done)
//   signature  - current MISR contents
//   count      - samples accepted in the current run
module bist_response_analyzer
  import bist_pkg::*;
#(
  parameter int unsigned      WIDTH    = 2,
  parameter int unsigned      SIG_W    = 16,
  parameter logic [SIG_W-1:0] POLY     = SIG_W'(DEFAULT_POLY),
  parameter logic [SIG_W-1:0] SEED     = '0,
  parameter int unsigned      PATTERNS = DEFAULT_PATTERNS
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic                              resp_valid,
  input  logic [WIDTH-1:0]                  resp,
  input  logic [SIG_W-1:0]                  golden,
  output logic                              busy,
  output logic                              done,
  output logic                              pass,
  output logic [SIG_W-1:0]                  signature,
  output logic [$clog2(PATTERNS+1)-1:0]     count
);

  localparam int unsigned CNT_W = $clog2(PATTERNS + 1);

  bist_state_t      r_state;
  bist_state_t      w_state_nxt;
  logic [CNT_W-1:0] r_count;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic             w_busy_nxt;
  logic             w_done_nxt;
  logic             w_start;
  logic             w_accept;
  logic             w_last;
  logic [SIG_W-1:0] w_sig;

  // start is only honoured from IDLE or DONE; samples only in CAPTURE below the limit
  assign w_start  = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_accept = resp_valid && (r_state == CAPTURE) && (r_count != CNT_W'(PATTERNS));
  assign w_last   = w_accept && (r_count == CNT_W'(PATTERNS - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_start) w_state_nxt = CAPTURE;
      CAPTURE: if (w_last)  w_state_nxt = COMPARE;
      COMPARE: w_state_nxt = DONE;
      DONE:    if (w_start) w_state_nxt = CAPTURE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Status outputs decoded from the upcoming state so they can be registered
  always_comb begin
    w_busy_nxt = 1'b0;
    w_done_nxt = 1'b0;
    unique case (w_state_nxt)
      CAPTURE, COMPARE: w_busy_nxt = 1'b1;
      DONE:             w_done_nxt = 1'b1;
      default: ;
    endcase
  end

  // Status, result and sample counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_count <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
      if (w_start) begin
        r_pass  <= 1'b0;
        r_count <= '0;
      end else begin
        if (r_state == COMPARE) begin
          r_pass <= (w_sig == golden);
        end
        if (w_accept) begin
          r_count <= r_count + CNT_W'(1);
        end
      end
    end
  end

  misr #(
    .WIDTH (WIDTH),
    .SIG_W (SIG_W),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_misr (
    .clk  (clk),
    .rst  (rst),
    .load (w_start),
    .en   (w_accept),
    .din  (resp),
    .sig  (w_sig)
  );

  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign signature = w_sig;
  assign count     = r_count;

endmodule

// File: tb/tb_bist_response_analyzer.sv
// Scoreboard bench for bist_response_analyzer (WIDTH=2, SIG_W=8, POLY=8'h1D).
module tb_bist_response_analyzer;

  localparam int POLY_I = 'h1D;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       resp_valid;
  logic [1:0] resp;
  logic [7:0] golden;
  logic       busy, done, pass;
  logic [7:0] signature;
  logic [2:0] count;

  // Second instance for the feedback-wrap case: SEED=8'h80, PATTERNS=1
  logic       s2_start;
  logic       s2_valid;
  logic [1:0] s2_resp;
  logic [7:0] s2_golden;
  logic       s2_busy, s2_done, s2_pass;
  logic [7:0] s2_sig;
  logic [0:0] s2_count;

  typedef struct packed {
    logic [7:0] sig;
    logic       pass;
  } exp_t;

  exp_t sb[$];
  int   vecs = 0;
  int   errs = 0;
  logic prev_done = 1'b0;

  always #5 clk = ~clk;

  bist_response_analyzer #(
    .WIDTH(2), .SIG_W(8), .POLY(8'h1D), .SEED(8'h00), .PATTERNS(4)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .resp_valid(resp_valid), .resp(resp),
    .golden(golden), .busy(busy), .done(done), .pass(pass),
    .signature(signature), .count(count)
  );

  bist_response_analyzer #(
    .WIDTH(2), .SIG_W(8), .POLY(8'h1D), .SEED(8'h80), .PATTERNS(1)
  ) dut2 (
    .clk(clk), .rst(rst), .start(s2_start), .resp_valid(s2_valid), .resp(s2_resp),
    .golden(s2_golden), .busy(s2_busy), .done(s2_done), .pass(s2_pass),
    .signature(s2_sig), .count(s2_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Signature as polynomial arithmetic: multiply by x modulo (x^8 + POLY), add the sample
  function automatic logic [7:0] misr_step(input logic [7:0] s, input logic [1:0] d);
    int v;
    v = int'(s) * 2;
    if (v >= 256) v = v ^ (256 + POLY_I);
    v = v ^ int'(d);
    return 8'(v);
  endfunction

  // Monitor: pops the expected result whenever the DUT enters DONE
  always @(negedge clk) begin
    exp_t e;
    if (done && !prev_done) begin
      if (sb.size() == 0) begin
        vecs++;
        errs++;
        $display("FAIL sb_unexpected_done: got done=1 expected no result pending");
      end else begin
        e = sb.pop_front();
        chk("sb_signature", 32'(signature), 32'(e.sig));
        chk("sb_pass", 32'(pass), 32'(e.pass));
      end
    end
    prev_done = done;
  end

  // mode 0: all zeros, 1: 01,00,00,00, 2: random; gap < 0 means random gaps
  task automatic do_run(input int mode, input int gap, input bit corrupt);
    logic [1:0] d[4];
    logic [7:0] exp_s;
    logic [7:0] run_s;
    int         n;
    int         g;
    for (int i = 0; i < 4; i++) begin
      if (mode == 0)      d[i] = 2'b00;
      else if (mode == 1) d[i] = (i == 0) ? 2'b01 : 2'b00;
      else                d[i] = 2'($urandom_range(0, 3));
    end
    exp_s = 8'h00;
    for (int i = 0; i < 4; i++) exp_s = misr_step(exp_s, d[i]);
    if (corrupt) golden = exp_s ^ ((mode == 2) ? 8'(1 << $urandom_range(0, 7)) : 8'h01);
    else         golden = exp_s;
    sb.push_back('{sig: exp_s, pass: (exp_s == golden)});

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_done", 32'(done), 32'd0);
    chk("start_count", 32'(count), 32'd0);
    chk("start_sig", 32'(signature), 32'h00);
    chk("start_pass", 32'(pass), 32'd0);

    run_s = 8'h00;
    n     = 0;
    for (int i = 0; i < 4; i++) begin
      g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
      repeat (g) begin
        resp_valid = 1'b0;
        resp       = 2'($urandom_range(0, 3));
        start      = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk("gap_count", 32'(count), 32'(n));
        chk("gap_sig", 32'(signature), 32'(run_s));
        chk("gap_busy", 32'(busy), 32'd1);
      end
      resp_valid = 1'b1;
      resp       = d[i];
      start      = 1'($urandom_range(0, 1));
      @(negedge clk);
      run_s = misr_step(run_s, d[i]);
      n++;
      chk("acc_count", 32'(count), 32'(n));
      chk("acc_sig", 32'(signature), 32'(run_s));
    end

    // COMPARE cycle: resp_valid and start must both be ignored here
    chk("cmp_busy", 32'(busy), 32'd1);
    chk("cmp_done", 32'(done), 32'd0);
    resp_valid = 1'b1;
    resp       = 2'($urandom_range(0, 3));
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    chk("done_done", 32'(done), 32'd1);
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_count", 32'(count), 32'd4);
    chk("done_sig", 32'(signature), 32'(exp_s));

    // DONE holds its results while resp_valid toggles
    resp_valid = 1'b1;
    resp       = 2'($urandom_range(0, 3));
    @(negedge clk);
    resp_valid = 1'b0;
    chk("hold_done", 32'(done), 32'd1);
    chk("hold_count", 32'(count), 32'd4);
    chk("hold_sig", 32'(signature), 32'(exp_s));
    chk("hold_pass", 32'(pass), 32'(exp_s == golden));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] wrap_s;
    rst        = 1'b1;
    start      = 1'b0;
    resp_valid = 1'b0;
    resp       = 2'b00;
    golden     = 8'h00;
    s2_start   = 1'b0;
    s2_valid   = 1'b0;
    s2_resp    = 2'b00;
    s2_golden  = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_sig", 32'(signature), 32'h00);
    chk("rst2_sig", 32'(s2_sig), 32'h80);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);

    do_run(0, 0, 1'b0);   // all zeros, pass
    do_run(1, 0, 1'b0);   // known sequence, golden 08
    do_run(1, 0, 1'b1);   // known sequence, golden 09
    do_run(1, 3, 1'b0);   // three idle cycles between samples

    // Reset mid-run after two samples
    start = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    resp_valid = 1'b1;
    resp       = 2'b11;
    repeat (2) @(negedge clk);
    resp_valid = 1'b0;
    chk("mid_count", 32'(count), 32'd2);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_pass", 32'(pass), 32'd0);
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_sig", 32'(signature), 32'h00);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_run(0, 0, 1'b0);

    // Feedback wrap on the second instance
    wrap_s    = misr_step(8'h80, 2'b00);
    s2_golden = wrap_s;
    s2_start  = 1'b1;
    @(negedge clk);
    s2_start = 1'b0;
    s2_valid = 1'b1;
    s2_resp  = 2'b00;
    @(negedge clk);
    s2_valid = 1'b0;
    chk("wrap_sig", 32'(s2_sig), 32'(wrap_s));
    chk("wrap_count", 32'(s2_count), 32'd1);
    chk("wrap_busy", 32'(s2_busy), 32'd1);
    @(negedge clk);
    chk("wrap_done", 32'(s2_done), 32'd1);
    chk("wrap_pass", 32'(s2_pass), 32'd1);

    // Randomized runs, restarting straight from DONE each time
    for (int r = 0; r < 24; r++) begin
      do_run(2, -1, 1'($urandom_range(0, 1)));
    end

    repeat (2) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
